// File: rtl/uart_pkg.sv
// Shared UART constants and status bundle.
package uart_pkg;

   localparam int UART_FIFO_DEPTH = 16;
   localparam int UART_DATA_W     = 8;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_full;
      logic overflow;
      logic underflow;
   } uart_fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read, no reset.
module uart_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO between host and UART with
// sticky overflow/underflow flags.
module uart_fifo
   import uart_pkg::*;
#(
   parameter  int DATA_W       = UART_DATA_W,
   parameter  int DEPTH        = UART_FIFO_DEPTH,
   parameter  int AFULL_THRESH = 12,
   localparam int ADDR_W       = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              almost_full_o,
   output logic [ADDR_W:0]   level_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] AF  = AFULL_THRESH[ADDR_W:0];

   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [DATA_W-1:0] rdata;
   logic              push_ok;
   logic              pop_ok;
   logic              flush;

   assign flush   = rst_i | clear_i;
   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0])
                  & (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
   assign level_o = wr_ptr - rd_ptr;
   assign almost_full_o = (level_o >= AF);

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_i);

   uart_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (push_ok & ~flush),
      .waddr_i (wr_ptr[ADDR_W-1:0]),
      .wdata_i (data_i),
      .raddr_i (rd_ptr[ADDR_W-1:0]),
      .rdata_o (rdata)
   );

   assign data_o = empty_o ? '0 : rdata;

   always_ff @(posedge clk_i) begin
      if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + ONE;
         if (push_i & full_o & ~pop_i) overflow_o  <= 1'b1;
         if (pop_i & empty_o)          underflow_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed vector bench for uart_fifo.
module tb_uart_fifo;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       push;
   logic [7:0] din;
   logic       pop;
   logic [7:0] dout;
   logic       empty;
   logic       full;
   logic       afull;
   logic [4:0] level;
   logic       ovf;
   logic       unf;

   int total = 0;
   int bad   = 0;

   uart_fifo dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .clear_i       (clear),
      .push_i        (push),
      .data_i        (din),
      .pop_i         (pop),
      .data_o        (dout),
      .empty_o       (empty),
      .full_o        (full),
      .almost_full_o (afull),
      .level_o       (level),
      .overflow_o    (ovf),
      .underflow_o   (unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       psh;
      logic       pp;
      logic [7:0] d;
      int         lvl;
      logic       emp;
      logic       ful;
      logic       af;
      logic       ov;
      logic       un;
      logic [7:0] q;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic c, input logic p, input logic q,
                       input logic [7:0] d);
      clear = c;
      push  = p;
      pop   = q;
      din   = d;
      @(posedge clk);
      #1;
      clear = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      din   = 8'h00;
   endtask

   task automatic chk_state(input string tag, input int lv, input logic e,
                            input logic f, input logic a, input logic o,
                            input logic u, input logic [7:0] q);
      chk({tag, ".level"}, int'(level), lv);
      chk({tag, ".empty"}, int'(empty), int'(e));
      chk({tag, ".full"},  int'(full),  int'(f));
      chk({tag, ".afull"}, int'(afull), int'(a));
      chk({tag, ".ovf"},   int'(ovf),   int'(o));
      chk({tag, ".unf"},   int'(unf),   int'(u));
      chk({tag, ".data"},  int'(dout),  int'(q));
   endtask

   initial begin
      rst   = 1'b1;
      clear = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      din   = 8'h00;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_state("reset", 0, 1, 0, 0, 0, 0, 8'h00);

      vt[0] = '{0, 1, 0, 8'h55, 1, 0, 0, 0, 0, 0, 8'h55};
      vt[1] = '{0, 1, 0, 8'hAA, 2, 0, 0, 0, 0, 0, 8'h55};
      vt[2] = '{0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 0, 8'hAA};
      vt[3] = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00};
      vt[4] = '{0, 1, 1, 8'h3C, 1, 0, 0, 0, 0, 1, 8'h3C};
      vt[5] = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00};
      vt[6] = '{1, 1, 0, 8'h11, 0, 1, 0, 0, 0, 0, 8'h00};
      vt[7] = '{0, 1, 1, 8'h22, 1, 0, 0, 0, 0, 1, 8'h22};
      vt[8] = '{0, 1, 1, 8'h33, 1, 0, 0, 0, 0, 1, 8'h33};
      vt[9] = '{1, 1, 1, 8'h44, 0, 1, 0, 0, 0, 0, 8'h00};

      for (int i = 0; i < 10; i++) begin
         step(vt[i].clr, vt[i].psh, vt[i].pp, vt[i].d);
         chk_state($sformatf("vec%0d", i), vt[i].lvl, vt[i].emp, vt[i].ful,
                   vt[i].af, vt[i].ov, vt[i].un, vt[i].q);
      end

      // fill, overflow, drain in order
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0, 8'(i));
         chk($sformatf("fill%0d.afull", i), int'(afull), int'(i >= 11));
         chk($sformatf("fill%0d.full", i),  int'(full),  int'(i == 15));
         chk($sformatf("fill%0d.head", i),  int'(dout),  0);
      end
      step(0, 1, 0, 8'hFF);
      chk_state("ovf", 16, 0, 1, 1, 1, 0, 8'h00);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d.data", i), int'(dout), i);
         step(0, 0, 1, 8'h00);
      end
      chk_state("drained", 0, 1, 0, 0, 1, 0, 8'h00);

      // full with simultaneous push and pop
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i));
      step(0, 1, 1, 8'h80);
      chk_state("fullpp", 16, 0, 1, 1, 0, 0, 8'h01);
      for (int i = 1; i < 17; i++) begin
         chk($sformatf("fpdrain%0d", i), int'(dout), (i == 16) ? 8'h80 : i);
         step(0, 0, 1, 8'h00);
      end
      chk_state("fpdone", 0, 1, 0, 0, 0, 0, 8'h00);

      // streaming through pointer wraps
      step(0, 1, 0, 8'hA0);
      for (int i = 1; i < 40; i++) begin
         chk($sformatf("stream%0d.level", i), int'(level), 1);
         chk($sformatf("stream%0d.head", i), int'(dout),
             int'(8'hA0 + 8'(i - 1)));
         step(0, 1, 1, 8'hA0 + 8'(i));
      end
      chk("stream.last", int'(dout), int'(8'hA0 + 8'd39));
      step(0, 0, 1, 8'h00);
      chk_state("streamdone", 0, 1, 0, 0, 0, 0, 8'h00);

      // reset mid-operation loses data and flags
      step(0, 1, 0, 8'h12);
      step(0, 1, 0, 8'h34);
      step(0, 0, 1, 8'h00);
      step(0, 0, 1, 8'h00);
      step(0, 0, 1, 8'h00);
      chk("pre_rst.unf", int'(unf), 1);
      step(0, 1, 0, 8'h56);
      rst = 1'b1;
      step(0, 1, 0, 8'h78);
      rst = 1'b0;
      chk_state("midrst", 0, 1, 0, 0, 0, 0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Synchronous first-word-fall-through FIFO that buffers UART data words between the host and `uart_controller`. One instance sits upstream of the transmitter: its `data_o` drives `tx_data_i`, `tx_fifo_pop_o` drives `pop_i`, and `~empty_o` drives `tx_start_i`. A second instance sits downstream of the receiver: `rx_data_o` drives `data_i` and `rx_fifo_push_o` drives `push_i`. Overflow and underflow are flagged and held, never silently absorbed.

## Interface
- `DATA_W`, default 8: word width; equals `MAX_UART_DATA_W`.
- `DEPTH`, default 16: number of entries; power of two, minimum 2.
- `AFULL_THRESH`, default 12: level at or above which `almost_full_o` asserts; range 1..DEPTH.
- `ADDR_W`, default $clog2(DEPTH): pointer index width; derived, not overridden.

Ports:
- `clk_i`  in  1  single clock for all logic.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous flush; empties the FIFO and clears the error flags.
- `push_i`  in  1  write strobe; one word per cycle.
- `data_i`  in  DATA_W  write data, sampled on a cycle where `push_i`=1.
- `pop_i`  in  1  read strobe; removes the head word.
- `data_o`  out  DATA_W  head word (FWFT); 0 when the FIFO is empty.
- `empty_o`  out  1  level == 0.
- `full_o`  out  1  level == DEPTH.
- `almost_full_o`  out  1  level >= AFULL_THRESH.
- `level_o`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `overflow_o`  out  1  sticky; a push was attempted while full.
- `underflow_o`  out  1  sticky; a pop was attempted while empty.

## Operation
- Storage is a DEPTH×DATA_W array. The array is not reset.
- Write pointer `wr_ptr` and read pointer `rd_ptr` are ADDR_W+1 bits wide. The MSB is a wrap bit.
  - Index = low ADDR_W bits.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the MSBs differ.
  - Level = `wr_ptr - rd_ptr`, modulo 2^(ADDR_W+1).
- Pointers increment by 1 and wrap naturally. DEPTH-1 → 0 index wrap toggles the MSB.
- Accepted push: mem[wr_idx] <= `data_i`, then `wr_ptr`++.
- Accepted pop: `rd_ptr`++.
- Acceptance rules:
  - Push while not full: accepted.
  - Push while full without a pop: dropped; `overflow_o` set.
  - Push and pop together while full: both accepted; level unchanged; head advances.
  - Pop while not empty: accepted.
  - Pop while empty: ignored; `underflow_o` set. A simultaneous push is still accepted.
- Push and pop together with 0 < level < DEPTH: both accepted; level unchanged.
- `clear_i` has priority over push and pop in the same cycle.
  - Pointers go to 0; both sticky flags go to 0.
  - A push in the same cycle is discarded and does not set `overflow_o`.
- `rst_i` mid-operation has the same effect as `clear_i`. Any stored words are lost.
- `data_o` = mem[rd_idx] read combinationally, gated to 0 while empty.
- Sticky flags clear only on `rst_i` or `clear_i`.

## Timing
- Reset values:
  - `empty_o`=1.
  - `full_o`=0, `almost_full_o`=0, `level_o`=0.
  - `data_o`=0.
  - `overflow_o`=0, `underflow_o`=0.
- All status outputs are decoded from registered pointers. They update in the cycle after the causing edge.
- Write latency is 1 cycle. A push at edge N gives `empty_o`=0 and `data_o`=word after edge N.
- Pop to next head is 1 cycle. After the pop edge, `data_o` shows the next word, or 0 if the FIFO is now empty.
- The FIFO sustains one push and one pop every cycle indefinitely.
- Error flags assert in the cycle after the offending strobe.
- There is no combinational path from `push_i` or `pop_i` to any output.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_FIFO_DEPTH` (16) and `UART_DATA_W` (8) constants.
  - A `uart_fifo_status_t` packed struct: empty, full, almost_full, overflow, underflow. This is used when exporting status to the register map.
- One sub-module is natural: `uart_fifo_ram`, a DEPTH×DATA_W array with synchronous write and asynchronous read.
- Pointer, flag and level logic lives in `uart_fifo`.
- Target size is about 150 RTL lines total.

## Test plan
- Reset then idle: after 5 reset cycles, `empty_o`=1, `level_o`=0, `data_o`=0, flags=0.
- Push 0x55, then 0xAA, with no pop: `level_o`=2, `data_o`=0x55. Pop once → `data_o`=0xAA. Pop again → `empty_o`=1, `data_o`=0.
- Fill 16 words 0x00..0x0F:
  - `almost_full_o` rises after the 12th push; `full_o` rises after the 16th.
  - A 17th push of 0xFF sets `overflow_o`.
  - Draining returns 0x00..0x0F in order; 0xFF never appears.
- Full plus simultaneous push 0x80 and pop: `level_o` stays 16, `overflow_o` stays 0, and 0x80 emerges last on drain.
- Pop while empty with a simultaneous push 0x3C: `underflow_o`=1, `level_o`=1, `data_o`=0x3C. A following `clear_i` → `level_o`=0 and both flags 0.
- Wrap and loopback:
  - Stream 40 words through at one push and one pop per cycle after the first push; pointers wrap twice.
  - A tx instance drives `uart_controller` at baud_sel=2'b11 with rx looped back.
  - An rx instance sees 0x55, 0xAA, and `rx_fifo_push_o` fills it in order.
